// File: rtl/imm_gen_if.sv
// Handshake bundle for imm_gen_pipe: instruction request in, extended immediate out.
// Valid/ready: a beat transfers on a rising clk edge where valid && ready are both high.
interface imm_gen_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      sel;
    logic            auto_mode;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;

    modport slave (
        input  in_valid, instr, sel, auto_mode, flush, out_ready,
        output in_ready, out_valid, imm, fmt, illegal
    );

    modport master (
        output in_valid, instr, sel, auto_mode, flush, out_ready,
        input  in_ready, out_valid, imm, fmt, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with one registered, backpressured output stage.
// Format comes from sel, or from the opcode/funct3 when auto decode is enabled.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter bit AUTO_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    imm_gen_if.slave  bus
);
    typedef enum logic [2:0] {
        FMT_I     = 3'b000,
        FMT_JALR  = 3'b001,
        FMT_SHAMT = 3'b010,
        FMT_S     = 3'b011,
        FMT_U     = 3'b100,
        FMT_J     = 3'b101,
        FMT_B     = 3'b110,
        FMT_ZIMM  = 3'b111
    } fmt_e;

    logic [31:0]     ins;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            auto_eff;
    fmt_e            fmt_d;
    logic            ill_d;
    logic [31:0]     raw32;
    logic [XLEN-1:0] imm_d;
    logic            load;
    logic            valid_d;

    logic            valid_q;
    logic [XLEN-1:0] imm_q;
    fmt_e            fmt_q;
    logic            ill_q;

    assign ins      = bus.instr;
    assign opcode   = ins[6:0];
    assign funct3   = ins[14:12];
    assign auto_eff = AUTO_EN && bus.auto_mode;

    always_comb begin : format_decode
        fmt_d = fmt_e'(bus.sel);
        ill_d = 1'b0;
        if (auto_eff) begin
            case (opcode)
                7'b0000011: fmt_d = FMT_I;
                7'b0010011: fmt_d = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
                7'b1100111: fmt_d = FMT_JALR;
                7'b0100011: fmt_d = FMT_S;
                7'b0110111,
                7'b0010111: fmt_d = FMT_U;
                7'b1101111: fmt_d = FMT_J;
                7'b1100011: fmt_d = FMT_B;
                7'b1110011: fmt_d = funct3[2] ? FMT_ZIMM : FMT_I;
                default: begin
                    fmt_d = FMT_ZIMM;
                    ill_d = 1'b1;
                end
            endcase
        end
    end

    // Every format fits a 32-bit value whose bit 31 is the correct extension
    // bit (zero for SHAMT/ZIMM), so widening to 64 is a plain sign-extension.
    always_comb begin : imm_build
        raw32 = '0;
        case (fmt_d)
            FMT_I:     raw32 = {{20{ins[31]}}, ins[31:20]};
            FMT_JALR:  raw32 = {{20{ins[31]}}, ins[31:21], 1'b0};
            FMT_SHAMT: raw32 = {26'b0, (XLEN == 64) ? ins[25] : 1'b0, ins[24:20]};
            FMT_S:     raw32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_U:     raw32 = {ins[31:12], 12'b0};
            FMT_J:     raw32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_B:     raw32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_ZIMM:  raw32 = {27'b0, ins[19:15]};
            default:   raw32 = '0;
        endcase
        if (ill_d) begin
            raw32 = '0;
        end
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm_d = {{32{raw32[31]}}, raw32};
        end else begin : g_x32
            assign imm_d = raw32;
        end
    endgenerate

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;

    // Flush wins over everything, including a same-cycle input handshake.
    always_comb begin : valid_next
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            imm_q   <= '0;
            fmt_q   <= FMT_I;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                imm_q <= imm_d;
                fmt_q <= fmt_d;
                ill_q <= ill_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.imm       = imm_q;
    assign bus.fmt       = fmt_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are checked every cycle against a queue-based reference model.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  sel = '0;
    logic        auto_mode = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_gen_if #(.XLEN(32)) bus32 ();
    imm_gen_if #(.XLEN(64)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.instr     = instr;
    assign bus32.sel       = sel;
    assign bus32.auto_mode = auto_mode;
    assign bus32.flush     = flush;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.instr     = instr;
    assign bus64.sel       = sel;
    assign bus64.auto_mode = auto_mode;
    assign bus64.flush     = flush;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .AUTO_EN(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .AUTO_EN(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    typedef struct packed {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    logic m_valid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: decides the format and evaluates the immediate's numeric value.
    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] s, input logic am);
        exp_t r;
        logic [2:0] f;
        logic [2:0] f3;
        logic [6:0] op;
        logic il;
        longint v64;
        longint v32;
        op = ins[6:0];
        f3 = ins[14:12];
        f = s;
        il = 1'b0;
        if (am) begin
            if (op == 7'h03) f = 3'd0;
            else if (op == 7'h13) f = (f3 == 3'd1 || f3 == 3'd5) ? 3'd2 : 3'd0;
            else if (op == 7'h67) f = 3'd1;
            else if (op == 7'h23) f = 3'd3;
            else if (op == 7'h37 || op == 7'h17) f = 3'd4;
            else if (op == 7'h6F) f = 3'd5;
            else if (op == 7'h63) f = 3'd6;
            else if (op == 7'h73) f = f3[2] ? 3'd7 : 3'd0;
            else begin
                f = 3'd7;
                il = 1'b1;
            end
        end
        case (f)
            3'd0: v64 = longint'($signed(ins[31:20]));
            3'd1: v64 = longint'($signed(ins[31:20])) & ~64'sd1;
            3'd2: v64 = longint'(ins[25:20]);
            3'd3: v64 = longint'($signed({ins[31:25], ins[11:7]}));
            3'd4: v64 = longint'($signed({ins[31:12], 12'h000}));
            3'd5: v64 = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd6: v64 = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            default: v64 = longint'(ins[19:15]);
        endcase
        v32 = (f == 3'd2) ? longint'(ins[24:20]) : v64;
        if (il) begin
            v64 = 0;
            v32 = 0;
        end
        r.imm32 = v32[31:0];
        r.imm64 = v64;
        r.fmt = f;
        r.ill = il;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic hs_in;
        logic hs_out;
        if (!rst_n) begin
            exp_q.delete();
            m_valid = 1'b0;
        end else begin
            hs_in = in_valid && (!m_valid || out_ready);
            hs_out = m_valid && out_ready;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (hs_out) void'(exp_q.pop_front());
                if (hs_in) exp_q.push_back(model(instr, sel, auto_mode));
            end
            m_valid = (exp_q.size() > 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("in_ready32", {63'b0, bus32.in_ready}, {63'b0, !m_valid || out_ready});
            chk("in_ready64", {63'b0, bus64.in_ready}, {63'b0, !m_valid || out_ready});
            chk("out_valid32", {63'b0, bus32.out_valid}, {63'b0, m_valid});
            chk("out_valid64", {63'b0, bus64.out_valid}, {63'b0, m_valid});
            if (m_valid) begin
                e = exp_q[0];
                chk("imm32", {32'b0, bus32.imm}, {32'b0, e.imm32});
                chk("imm64", bus64.imm, e.imm64);
                chk("fmt32", {61'b0, bus32.fmt}, {61'b0, e.fmt});
                chk("fmt64", {61'b0, bus64.fmt}, {61'b0, e.fmt});
                chk("illegal32", {63'b0, bus32.illegal}, {63'b0, e.ill});
                chk("illegal64", {63'b0, bus64.illegal}, {63'b0, e.ill});
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] ins, input logic [2:0] s,
                       input logic am, input logic f, input logic r);
        in_valid = v;
        instr = ins;
        sel = s;
        auto_mode = am;
        flush = f;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] vecs [12] = '{
        32'h00812083, 32'h00311093, 32'h43F1D093, 32'hFE112E23,
        32'hFFDFF0EF, 32'hFFFFF117, 32'h3400D073, 32'h34011073,
        32'h00008067, 32'h80000063, 32'h7FF00013, 32'h0000000B
    };

    initial begin
        exp_t p;
        p = model(32'hFE000EE3, 3'd0, 1'b1);
        chk("pin_beq", p.imm64, 64'hFFFFFFFFFFFFFFFC);
        p = model(32'h43F1D093, 3'd0, 1'b1);
        chk("pin_srai32", {32'b0, p.imm32}, 64'd31);
        chk("pin_srai64", p.imm64, 64'd63);
        p = model(32'hFFDFF0EF, 3'd0, 1'b1);
        chk("pin_jal", p.imm64, 64'hFFFFFFFFFFFFFFFC);

        #3;
        chk("rst_out_valid", {63'b0, bus32.out_valid}, 64'd0);
        chk("rst_imm", {32'b0, bus32.imm}, 64'd0);
        chk("rst_in_ready", {63'b0, bus32.in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        cyc(1'b1, 32'hFFF00093, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("addi_valid", {63'b0, bus32.out_valid}, 64'd1);
        chk("addi_imm", {32'b0, bus32.imm}, 64'hFFFFFFFF);
        chk("addi_fmt", {61'b0, bus32.fmt}, 64'd0);
        chk("addi_ill", {63'b0, bus32.illegal}, 64'd0);
        cyc(1'b1, 32'hFE000EE3, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("beq_imm", {32'b0, bus32.imm}, 64'hFFFFFFFC);
        chk("beq_fmt", {61'b0, bus32.fmt}, 64'd6);
        cyc(1'b1, 32'h123450B7, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("lui_imm32", {32'b0, bus32.imm}, 64'h12345000);
        chk("lui_imm64", bus64.imm, 64'h0000000012345000);
        chk("lui_fmt", {61'b0, bus32.fmt}, 64'd4);
        cyc(1'b1, 32'h00308067, 3'd1, 1'b0, 1'b0, 1'b1);
        chk("jalr_man_imm", {32'b0, bus32.imm}, 64'd2);
        cyc(1'b1, 32'h0000007F, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("illeg_flag", {63'b0, bus32.illegal}, 64'd1);
        chk("illeg_imm", {32'b0, bus32.imm}, 64'd0);
        chk("illeg_fmt", {61'b0, bus32.fmt}, 64'd7);
        cyc(1'b1, 32'h0000007F, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("manual_no_illegal", {63'b0, bus32.illegal}, 64'd0);

        foreach (vecs[i]) cyc(1'b1, vecs[i], 3'd0, 1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 8; s++) cyc(1'b1, 32'hDEADBEEF, 3'(s), 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);

        cyc(1'b1, 32'h00100093, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_first", {32'b0, bus32.imm}, 64'd1);
        cyc(1'b1, 32'h00200093, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_in_ready", {63'b0, bus32.in_ready}, 64'd0);
        chk("bp_hold1", {32'b0, bus32.imm}, 64'd1);
        cyc(1'b1, 32'h00200093, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_hold2", {32'b0, bus32.imm}, 64'd1);
        cyc(1'b1, 32'h00200093, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("bp_second", {32'b0, bus32.imm}, 64'd2);
        cyc(1'b1, 32'h00300093, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("bp_third", {32'b0, bus32.imm}, 64'd3);
        cyc(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("bp_drained", {63'b0, bus32.out_valid}, 64'd0);

        cyc(1'b1, 32'h00500093, 3'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h00600093, 3'd0, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", {63'b0, bus32.out_valid}, 64'd0);
        cyc(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("flush_discard", {63'b0, bus32.out_valid}, 64'd0);

        cyc(1'b1, 32'h00700093, 3'd0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00800093;
        out_ready = 1'b1;
        #1;
        chk("arst_valid", {63'b0, bus32.out_valid}, 64'd0);
        chk("arst_imm", {32'b0, bus32.imm}, 64'd0);
        chk("arst_in_ready", {63'b0, bus32.in_ready}, 64'd1);
        @(posedge clk);
        #2;
        chk("arst_no_accept", {63'b0, bus32.out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("post_rst_idle", {63'b0, bus32.out_valid}, 64'd0);
        cyc(1'b1, 32'h00900093, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("post_rst_first", {32'b0, bus32.imm}, 64'd9);

        for (int i = 0; i < 24; i++)
            cyc(i % 4 != 1, vecs[i % 12], 3'(i % 8), i % 5 != 0, i == 13, i % 3 != 0);
        cyc(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
